// File: rtl/conv_loop_sequencer_pkg.sv
// Shared widths, sequencer state encoding and index helpers for the
// convolution loop-nest sequencer.
package conv_loop_sequencer_pkg;

  localparam int BYTE      = 8;
  localparam int HALF_WORD = 16;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

  // Value a wrap_counter will hold after the current edge.
  function automatic logic [BYTE-1:0] next_idx(input logic [BYTE-1:0] v,
                                                input logic            inc,
                                                input logic            wrap);
    if (wrap)     return '0;
    else if (inc) return v + 1'b1;
    else          return v;
  endfunction

  function automatic logic signed [HALF_WORD-1:0] to_hw(input logic [BYTE-1:0] v);
    return $signed({{(HALF_WORD-BYTE){1'b0}}, v});
  endfunction

endpackage

// File: rtl/conv_loop_sequencer_wrap.sv
// Byte-wide wrapping index counter; wrap is the carry into the next outer index.
module wrap_counter
  import conv_loop_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            clr,
  input  logic [BYTE-1:0] max,
  output logic [BYTE-1:0] value,
  output logic            wrap
);

  logic [BYTE-1:0] value_q;

  assign wrap  = inc && (value_q == max);
  assign value = value_q;

  always_ff @(posedge clk) begin
    if (reset)      value_q <= '0;
    else if (clr)   value_q <= '0;
    else if (wrap)  value_q <= '0;
    else if (inc)   value_q <= value_q + 1'b1;
  end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Convolution loop-nest sequencer: walks j,k,i,m,n,l and issues taps.
// Optional padding-tap detection is built when PAD_DETECT_EN is defined.
module conv_loop_sequencer
  import conv_loop_sequencer_pkg::*;
#(
  parameter logic [BYTE-1:0] CONV_DIM_IMG    = 8'd32,
  parameter logic [BYTE-1:0] CONV_DIM_KERNEL = 8'd5,
  parameter logic [BYTE-1:0] CONV_DIM_CH     = 8'd3,
  parameter logic [BYTE-1:0] CONV_OUT_CH     = 8'd32,
  parameter logic [BYTE-1:0] CONV_DIM_OUT    = 8'd32,
  parameter logic [BYTE-1:0] STRIDE          = 8'd1,
  parameter logic [BYTE-1:0] PADDING         = 8'd2,
  parameter logic [BYTE-1:0] PIPE_DEPTH      = 8'd2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  output logic [BYTE-1:0] i,
  output logic [BYTE-1:0] j,
  output logic [BYTE-1:0] k,
  output logic [BYTE-1:0] m,
  output logic [BYTE-1:0] n,
  output logic [BYTE-1:0] l,
  output logic            enable,
  output logic            acc_clr,
  output logic            en_save,
  output logic            pad,
  output logic            busy,
  output logic            done
);

  seq_state_e state_q;
  logic [3:0] drain_cnt_q;
  logic       enable_q, acc_clr_q, en_save_q, busy_q, done_q;
  logic       l_wrap, n_wrap, m_wrap, i_wrap, k_wrap, j_wrap;
  logic       all_max, mnl_max, advance, idx_clr;

  assign mnl_max = (l == CONV_DIM_CH - 8'd1) && (n == CONV_DIM_KERNEL - 8'd1) &&
                   (m == CONV_DIM_KERNEL - 8'd1);
  assign all_max = mnl_max && (i == CONV_OUT_CH - 8'd1) &&
                   (k == CONV_DIM_OUT - 8'd1) && (j == CONV_DIM_OUT - 8'd1);
  // The final tap holds the indices at max instead of wrapping them.
  assign advance = (state_q == SEQ_RUN) && !stall && !all_max;
  assign idx_clr = (state_q == SEQ_IDLE) || (state_q == SEQ_DONE);

  wrap_counter u_l (.clk(clk), .reset(reset), .inc(advance), .clr(idx_clr),
                    .max(CONV_DIM_CH - 8'd1), .value(l), .wrap(l_wrap));
  wrap_counter u_n (.clk(clk), .reset(reset), .inc(l_wrap), .clr(idx_clr),
                    .max(CONV_DIM_KERNEL - 8'd1), .value(n), .wrap(n_wrap));
  wrap_counter u_m (.clk(clk), .reset(reset), .inc(n_wrap), .clr(idx_clr),
                    .max(CONV_DIM_KERNEL - 8'd1), .value(m), .wrap(m_wrap));
  wrap_counter u_i (.clk(clk), .reset(reset), .inc(m_wrap), .clr(idx_clr),
                    .max(CONV_OUT_CH - 8'd1), .value(i), .wrap(i_wrap));
  wrap_counter u_k (.clk(clk), .reset(reset), .inc(i_wrap), .clr(idx_clr),
                    .max(CONV_DIM_OUT - 8'd1), .value(k), .wrap(k_wrap));
  wrap_counter u_j (.clk(clk), .reset(reset), .inc(k_wrap), .clr(idx_clr),
                    .max(CONV_DIM_OUT - 8'd1), .value(j), .wrap(j_wrap));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEQ_IDLE;
      drain_cnt_q <= '0;
      enable_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      en_save_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      en_save_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        SEQ_IDLE: begin
          if (start) begin
            state_q   <= SEQ_RUN;
            enable_q  <= 1'b1;
            acc_clr_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        SEQ_RUN: begin
          en_save_q <= enable_q && mnl_max;
          if (stall) begin
            enable_q  <= 1'b0;
            acc_clr_q <= 1'b0;
          end else if (all_max) begin
            state_q     <= SEQ_DRAIN;
            enable_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
            drain_cnt_q <= PIPE_DEPTH[3:0] - 4'd1;
          end else begin
            enable_q  <= 1'b1;
            acc_clr_q <= m_wrap;
          end
        end
        SEQ_DRAIN: begin
          if (drain_cnt_q == 4'd0) begin
            state_q <= SEQ_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - 4'd1;
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  assign enable  = enable_q;
  assign acc_clr = acc_clr_q;
  assign en_save = en_save_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef PAD_DETECT_EN
  logic [BYTE-1:0]             nj, nk, nm, nn;
  logic signed [HALF_WORD-1:0] row_d, col_d;
  logic                        pad_d, pad_q, tap_load;

  assign nj = next_idx(j, k_wrap, j_wrap);
  assign nk = next_idx(k, i_wrap, k_wrap);
  assign nm = next_idx(m, n_wrap, m_wrap);
  assign nn = next_idx(n, l_wrap, n_wrap);
  assign row_d = to_hw(STRIDE) * to_hw(nj) + to_hw(nm) - to_hw(PADDING);
  assign col_d = to_hw(STRIDE) * to_hw(nk) + to_hw(nn) - to_hw(PADDING);
  assign pad_d = row_d[HALF_WORD-1] || (row_d >= to_hw(CONV_DIM_IMG)) ||
                 col_d[HALF_WORD-1] || (col_d >= to_hw(CONV_DIM_IMG));
  assign tap_load = ((state_q == SEQ_IDLE) && start) || advance;

  always_ff @(posedge clk) begin
    if (reset)                                  pad_q <= 1'b0;
    else if (tap_load)                          pad_q <= pad_d;
    else if (!((state_q == SEQ_RUN) && stall))  pad_q <= 1'b0;
  end

  assign pad = pad_q;
`else
  logic unused_pad_cfg;
  assign unused_pad_cfg = ^{CONV_DIM_IMG, STRIDE, PADDING, j_wrap};
  assign pad = 1'b0;
`endif

endmodule
